// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle for the fetch_decode_queue.
// master = fetch+decode side, slave = queue.
interface fetch_decode_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]          instruction;
    logic [DATA_W-1:0]          pc;
    logic                       hit;
    logic                       flush;
    logic                       decode_ready;
    logic [DATA_W-1:0]          inst_out;
    logic [DATA_W-1:0]          pc_out;
    logic                       out_valid;
    logic                       full;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output instruction, pc, hit, flush, decode_ready,
        input  inst_out, pc_out, out_valid, full, count
    );

    modport slave (
        input  instruction, pc, hit, flush, decode_ready,
        output inst_out, pc_out, out_valid, full, count
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular instruction queue between fetch and decode, flushed on redirect.
// Optional same-cycle empty-queue bypass: define FDQ_BYPASS_EN.
module fetch_decode_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    fetch_decode_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               empty;
    logic               is_full;
    logic               bypass;
    logic               push;
    logic               pop;

    assign empty   = (cnt == '0);
    assign is_full = (cnt == CNT_W'(DEPTH));

`ifdef FDQ_BYPASS_EN
    assign bypass = empty & bus.hit & ~bus.flush & bus.decode_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word is consumed directly and never stored.
    assign push = bus.hit & ~is_full & ~bus.flush & ~bypass;
    assign pop  = bus.decode_ready & ~empty & ~bus.flush;

    // Entry storage; contents need no reset since count gates the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{instr: bus.instruction, pc: bus.pc};
        end
    end

    // Pointers and occupancy; flush clears everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Show-ahead head; NOP and zero PC when nothing is available.
    always_comb begin
        bus.inst_out  = '0;
        bus.pc_out    = '0;
        bus.out_valid = 1'b0;
        unique case (1'b1)
            bypass: begin
                bus.inst_out  = bus.instruction;
                bus.pc_out    = bus.pc;
                bus.out_valid = 1'b1;
            end
            !empty: begin
                bus.inst_out  = mem[rd_ptr].instr;
                bus.pc_out    = mem[rd_ptr].pc;
                bus.out_valid = 1'b1;
            end
            default: begin
                bus.out_valid = 1'b0;
            end
        endcase
    end

    assign bus.full  = is_full;
    assign bus.count = cnt;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (DEPTH=4).
// Expected values are hand-computed constants or a simple word index.
module tb_fetch_decode_queue;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    fetch_decode_queue_if #(.DEPTH(4), .DATA_W(32)) bus ();

    fetch_decode_queue #(.DEPTH(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic f, input logic d,
                         input logic [31:0] i, input logic [31:0] p);
        bus.hit          = h;
        bus.flush        = f;
        bus.decode_ready = d;
        bus.instruction  = i;
        bus.pc           = p;
    endtask

    function automatic logic [31:0] wd(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] wp(input int k);
        return 32'h0000_0100 + 32'(4 * k);
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        check("rst_count", 32'(bus.count), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_full", 32'(bus.full), 0);
        check("rst_inst", bus.inst_out, 0);
        check("rst_pc", bus.pc_out, 0);
        rst = 1'b0;

        // single push
        drive(1, 0, 0, 32'h2008_0005, 32'h4);
        #1;
        check("pre_push_valid", 32'(bus.out_valid), 0);
        step();
        check("p1_valid", 32'(bus.out_valid), 1);
        check("p1_inst", bus.inst_out, 32'h2008_0005);
        check("p1_pc", bus.pc_out, 32'h4);
        check("p1_count", 32'(bus.count), 1);

        // fill to full, then a dropped fifth word
        drive(1, 0, 0, 32'h11, 32'h8);
        step();
        drive(1, 0, 0, 32'h22, 32'hC);
        step();
        check("not_full_3", 32'(bus.full), 0);
        drive(1, 0, 0, 32'h33, 32'h10);
        step();
        check("full", 32'(bus.full), 1);
        check("full_count", 32'(bus.count), 4);
        drive(1, 0, 0, 32'hDEAD_BEEF, 32'h14);
        step();
        check("drop_count", 32'(bus.count), 4);
        check("drop_head", bus.inst_out, 32'h2008_0005);

        // drain in order; hit with full+pop must still be refused
        drive(1, 0, 1, 32'hDEAD_BEEF, 32'h14);
        check("pop0", bus.inst_out, 32'h2008_0005);
        step();
        check("fall_full", 32'(bus.full), 0);
        check("pop_full_count", 32'(bus.count), 3);
        drive(0, 0, 1, 0, 0);
        check("pop1", bus.inst_out, 32'h11);
        step();
        check("pop2", bus.inst_out, 32'h22);
        check("pop2_pc", bus.pc_out, 32'hC);
        step();
        check("pop3", bus.inst_out, 32'h33);
        step();
        check("empty_valid", 32'(bus.out_valid), 0);
        check("empty_inst", bus.inst_out, 0);
        check("empty_count", 32'(bus.count), 0);
        step();
        check("underflow_count", 32'(bus.count), 0);

        // steady push+pop at count 2, wrapping pointers
        drive(1, 0, 0, wd(0), wp(0));
        step();
        drive(1, 0, 0, wd(1), wp(1));
        step();
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 1, wd(k + 2), wp(k + 2));
            check($sformatf("stream_inst%0d", k), bus.inst_out, wd(k));
            check($sformatf("stream_pc%0d", k), bus.pc_out, wp(k));
            step();
            check($sformatf("stream_cnt%0d", k), 32'(bus.count), 2);
        end
        check("stream_head", bus.inst_out, wd(10));

        // third word, then flush with hit and decode_ready
        drive(1, 0, 0, wd(12), wp(12));
        step();
        check("pre_flush_count", 32'(bus.count), 3);
        drive(1, 1, 1, 32'hBAD0_0001, 32'h200);
        step();
        check("flush_count", 32'(bus.count), 0);
        check("flush_valid", 32'(bus.out_valid), 0);
        check("flush_inst", bus.inst_out, 0);
        drive(1, 0, 0, 32'h55, 32'h58);
        step();
        check("post_flush_inst", bus.inst_out, 32'h55);
        check("post_flush_count", 32'(bus.count), 1);

        // async reset between edges at count 3
        drive(1, 0, 0, 32'h66, 32'h5C);
        step();
        drive(1, 0, 0, 32'h77, 32'h60);
        step();
        drive(0, 0, 0, 0, 0);
        check("pre_rst_count", 32'(bus.count), 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(bus.count), 0);
        check("arst_valid", 32'(bus.out_valid), 0);
        check("arst_inst", bus.inst_out, 0);
        check("arst_pc", bus.pc_out, 0);
        #2;
        rst = 1'b0;
        drive(1, 0, 0, 32'h99, 32'h64);
        step();
        check("after_rst_push", bus.inst_out, 32'h99);
        check("after_rst_count", 32'(bus.count), 1);

        // drain then empty-queue hit with decode_ready
        drive(0, 0, 1, 0, 0);
        step();
        check("drain_count", 32'(bus.count), 0);
        drive(1, 0, 1, 32'h8C09_0000, 32'h40);
        #1;
`ifdef FDQ_BYPASS_EN
        check("byp_valid", 32'(bus.out_valid), 1);
        check("byp_inst", bus.inst_out, 32'h8C09_0000);
        check("byp_pc", bus.pc_out, 32'h40);
        step();
        drive(0, 0, 0, 0, 0);
        #1;
        check("byp_count", 32'(bus.count), 0);
        check("byp_after_valid", 32'(bus.out_valid), 0);
`else
        check("nobyp_valid", 32'(bus.out_valid), 0);
        check("nobyp_inst", bus.inst_out, 0);
        step();
        drive(0, 0, 0, 0, 0);
        #1;
        check("nobyp_count", 32'(bus.count), 1);
        check("nobyp_after_valid", 32'(bus.out_valid), 1);
        check("nobyp_after_inst", bus.inst_out, 32'h8C09_0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
